// File: rtl/button_deb_multi_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : button_deb_multi_pkg
// Description : Shared definitions for the multi-channel button debouncer.
//               The package holds the per-channel FSM state encoding and a
//               constant function that sizes the counters.
// Contents    : deb_state_t - STABLE / CHANGING channel state
//               clog2_w()   - ceil(log2(value)), minimum 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package button_deb_multi_pkg;

    // Explicit 1-bit encoding for the per-channel debounce state.
    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    // Bits needed to hold the values 0..value-1. Callers pass (max + 1) to
    // size a counter whose terminal value is max. Never returns less than 1,
    // so that degenerate parameters still give a legal vector.
    function automatic int clog2_w(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : button_deb_multi_pkg
`default_nettype wire

// File: rtl/button_deb_chan.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : button_deb_chan
// Description : One debounce channel: 2-flop synchroniser, STABLE/CHANGING
//               FSM with a tick-driven debounce counter, press/release edge
//               pulses and a saturating hold counter with long-press pulse.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous reset, active low
//               button_i  - raw asynchronous button level
//               tick_i    - one-cycle millisecond tick from shared prescaler
//               valid_o   - debounced level
//               press_o   - one-cycle pulse on debounced 0->1
//               release_o - one-cycle pulse on debounced 1->0
//               long_o    - one-cycle pulse when held LONG_PRESS_MS ticks
// Revision    : 1.0 - initial release
// ============================================================================
module button_deb_chan #(
    parameter int DEBOUNCE_PER_MS = 20,
    parameter int LONG_PRESS_MS   = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_i,
    input  logic tick_i,
    output logic valid_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    import button_deb_multi_pkg::*;

    localparam int DEB_W  = clog2_w(DEBOUNCE_PER_MS + 1);
    localparam int HOLD_W = clog2_w(LONG_PRESS_MS + 1);

    typedef logic [DEB_W-1:0]  deb_cnt_t;
    typedef logic [HOLD_W-1:0] hold_cnt_t;

    localparam deb_cnt_t  C_DEB_LAST = deb_cnt_t'(DEBOUNCE_PER_MS - 1);
    localparam hold_cnt_t C_LONG     = hold_cnt_t'(LONG_PRESS_MS);
    localparam logic      C_LONG_EN  = (LONG_PRESS_MS != 0);

    logic       r_sync1_q;
    logic       r_sync2_q;
    deb_state_t state_q,   state_d;
    deb_cnt_t   deb_q,     deb_d;
    logic       valid_q,   valid_d;
    logic       press_q,   press_d;
    logic       release_q, release_d;
    hold_cnt_t  hold_q,    hold_d;
    logic       long_q,    long_d;

    // Count only as part of an ongoing CHANGING interval; a fresh change
    // always starts from zero.
    deb_cnt_t   w_deb_cur;
    assign w_deb_cur = (state_q == ST_CHANGING) ? deb_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            state_q   <= ST_STABLE;
            deb_q     <= '0;
            valid_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
            long_q    <= 1'b0;
        end else begin
            r_sync1_q <= button_i;
            r_sync2_q <= r_sync1_q;
            state_q   <= state_d;
            deb_q     <= deb_d;
            valid_q   <= valid_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        valid_d   = valid_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = hold_q;
        long_d    = 1'b0;

        // Debounce: agreement always clears, even on a tick cycle. The
        // level flips on the tick that brings the count to
        // DEBOUNCE_PER_MS, and the edge pulse is registered alongside it
        // so both appear in the same cycle.
        if (r_sync2_q == valid_q) begin
            state_d = ST_STABLE;
            deb_d   = '0;
        end else if (tick_i && (w_deb_cur == C_DEB_LAST)) begin
            valid_d   = ~valid_q;
            press_d   = ~valid_q;
            release_d = valid_q;
            state_d   = ST_STABLE;
            deb_d     = '0;
        end else begin
            state_d = ST_CHANGING;
            deb_d   = tick_i ? (w_deb_cur + 1'b1) : w_deb_cur;
        end

        // Hold counter saturates at C_LONG, so the long-press pulse can
        // fire only once per press; with C_LONG == 0 it never moves.
        if (!valid_q) begin
            hold_d = '0;
        end else if (tick_i && C_LONG_EN && (hold_q != C_LONG)) begin
            hold_d = hold_q + 1'b1;
            long_d = ((hold_q + 1'b1) == C_LONG);
        end
    end

    assign valid_o   = valid_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule : button_deb_chan
`default_nettype wire

// File: rtl/button_deb_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : button_deb_multi
// Description : NB_BUTTONS independent button debouncers sharing a single
//               millisecond prescaler.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous reset, active low
//               button_in     - raw button levels, bit i = channel i
//               button_valid  - debounced levels
//               press_pulse   - one-cycle pulse per channel on 0->1
//               release_pulse - one-cycle pulse per channel on 1->0
//               long_press    - one-cycle pulse per channel after
//                               LONG_PRESS_MS of continuous hold
// Revision    : 1.0 - initial release
// ============================================================================
module button_deb_multi #(
    parameter int CLK_FREQ        = 95_000,
    parameter int DEBOUNCE_PER_MS = 20,
    parameter int NB_BUTTONS      = 4,
    parameter int LONG_PRESS_MS   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NB_BUTTONS-1:0] button_in,
    output logic [NB_BUTTONS-1:0] button_valid,
    output logic [NB_BUTTONS-1:0] press_pulse,
    output logic [NB_BUTTONS-1:0] release_pulse,
    output logic [NB_BUTTONS-1:0] long_press
);
    import button_deb_multi_pkg::*;

    localparam int PRE_W = clog2_w(CLK_FREQ);
    typedef logic [PRE_W-1:0] pre_cnt_t;
    localparam pre_cnt_t C_PRE_LAST = pre_cnt_t'(CLK_FREQ - 1);

    pre_cnt_t pre_q, pre_d;
    logic     w_tick;

    // Tick is high for the single cycle in which the prescaler wraps.
    assign w_tick = (pre_q == C_PRE_LAST);

    always_comb begin
        pre_d = w_tick ? '0 : (pre_q + 1'b1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar gi = 0; gi < NB_BUTTONS; gi++) begin : g_chan
        button_deb_chan #(
            .DEBOUNCE_PER_MS (DEBOUNCE_PER_MS),
            .LONG_PRESS_MS   (LONG_PRESS_MS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .button_i  (button_in[gi]),
            .tick_i    (w_tick),
            .valid_o   (button_valid[gi]),
            .press_o   (press_pulse[gi]),
            .release_o (release_pulse[gi]),
            .long_o    (long_press[gi])
        );
    end : g_chan

endmodule : button_deb_multi
`default_nettype wire

// File: tb/tb_button_deb_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_button_deb_multi
// Description : Directed self-checking bench for button_deb_multi with
//               CLK_FREQ=10, DEBOUNCE_PER_MS=4, LONG_PRESS_MS=8, 2 channels,
//               plus a LONG_PRESS_MS=0 instance driven with the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_deb_multi;

    logic       clk;
    logic       rst;
    logic [1:0] button_in;
    logic [1:0] button_valid, press_pulse, release_pulse, long_press;
    logic [1:0] nl_valid, nl_press, nl_release, nl_long;

    button_deb_multi #(
        .CLK_FREQ(10), .DEBOUNCE_PER_MS(4), .NB_BUTTONS(2), .LONG_PRESS_MS(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button_in     (button_in),
        .button_valid  (button_valid),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    button_deb_multi #(
        .CLK_FREQ(10), .DEBOUNCE_PER_MS(4), .NB_BUTTONS(2), .LONG_PRESS_MS(0)
    ) dut_nolong (
        .clk           (clk),
        .rst           (rst),
        .button_in     (button_in),
        .button_valid  (nl_valid),
        .press_pulse   (nl_press),
        .release_pulse (nl_release),
        .long_press    (nl_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int press_cnt [2];
    int rel_cnt   [2];
    int long_cnt  [2];
    int press_cyc [2];
    int rise_cyc  [2];
    int long_cyc  [2];
    int both_cnt  = 0;
    int pulse_err = 0;
    int nolong_cnt = 0;
    logic [1:0] vprev = 2'b00;
    int c0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < 2; ch++) begin
            press_cnt[ch] = 0;
            rel_cnt[ch]   = 0;
            long_cnt[ch]  = 0;
            press_cyc[ch] = -1;
            rise_cyc[ch]  = -1;
            long_cyc[ch]  = -1;
        end
        both_cnt = 0;
    endtask

    // Advance one clock, then sample #1 after the rising edge.
    task automatic tick1();
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            if (press_pulse[ch]) begin
                press_cnt[ch]++;
                press_cyc[ch] = cyc;
            end
            if (release_pulse[ch]) rel_cnt[ch]++;
            if (long_press[ch]) begin
                long_cnt[ch]++;
                long_cyc[ch] = cyc;
            end
            if (rst) begin
                // Edge pulses must match debounced transitions exactly.
                if ((button_valid[ch] && !vprev[ch]) != press_pulse[ch]) pulse_err++;
                if ((!button_valid[ch] && vprev[ch]) != release_pulse[ch]) pulse_err++;
            end
            if (button_valid[ch] && !vprev[ch]) rise_cyc[ch] = cyc;
        end
        if (press_pulse == 2'b11) both_cnt++;
        if (nl_long != 2'b00) nolong_cnt++;
        vprev = button_valid;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    initial begin
        rst       = 1'b0;
        button_in = 2'b00;
        clear_counts();

        // Reset state
        run(3);
        chk("rst_valid",   int'(button_valid),  0);
        chk("rst_press",   int'(press_pulse),   0);
        chk("rst_release", int'(release_pulse), 0);
        chk("rst_long",    int'(long_press),    0);
        rst = 1'b1;
        run(5);

        // Clean press on ch0, 60 cycles
        clear_counts();
        c0 = cyc;
        button_in = 2'b01;
        run(60);
        chk("clean_lat_in_32_42", int'((rise_cyc[0] - c0 >= 32) && (rise_cyc[0] - c0 <= 42)), 1);
        chk("clean_press0_cnt", press_cnt[0], 1);
        chk("clean_press_at_rise", press_cyc[0], rise_cyc[0]);
        chk("clean_ch1_untouched", int'({button_valid[1], press_cnt[1] != 0}), 0);
        button_in = 2'b00;
        run(60);
        chk("clean_release0_cnt", rel_cnt[0], 1);
        chk("clean_valid_after", int'(button_valid), 0);
        chk("clean_no_long", long_cnt[0], 0);

        // Bounce on ch0
        clear_counts();
        button_in = 2'b01; run(15);
        button_in = 2'b00; run(15);
        button_in = 2'b01; run(25);
        button_in = 2'b00; run(15);
        chk("bounce_no_press", press_cnt[0], 0);
        chk("bounce_valid_low", int'(button_valid[0]), 0);
        button_in = 2'b01; run(60);
        chk("bounce_one_press", press_cnt[0], 1);
        chk("bounce_no_release", rel_cnt[0], 0);
        chk("bounce_valid_high", int'(button_valid[0]), 1);
        button_in = 2'b00; run(60);
        chk("bounce_one_release", rel_cnt[0], 1);

        // Long hold on ch1
        clear_counts();
        button_in = 2'b10; run(120);
        button_in = 2'b00; run(60);
        chk("hold_press1", press_cnt[1], 1);
        chk("hold_long1_cnt", long_cnt[1], 1);
        chk("hold_long1_delay", long_cyc[1] - rise_cyc[1], 80);
        chk("hold_release1", rel_cnt[1], 1);
        chk("hold_ch0_quiet", press_cnt[0] + rel_cnt[0] + long_cnt[0], 0);

        // Simultaneous rise on both channels
        clear_counts();
        button_in = 2'b11; run(60);
        chk("both_press_same_cycle", both_cnt, 1);
        chk("both_press_cnt", press_cnt[0] + press_cnt[1], 2);
        button_in = 2'b00; run(60);
        chk("both_release_cnt", rel_cnt[0] + rel_cnt[1], 2);

        // Reset in the middle of a ch0 CHANGING interval, ch1 already high
        button_in = 2'b10; run(50);
        button_in = 2'b11; run(20);
        chk("prerst_valid", int'(button_valid), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid",   int'(button_valid),  0);
        chk("midrst_pulses",  int'({press_pulse, release_pulse, long_press}), 0);
        run(3);
        rst = 1'b1;
        clear_counts();
        c0 = cyc;
        run(60);
        chk("postrst_press0", press_cnt[0], 1);
        chk("postrst_press1", press_cnt[1], 1);
        chk("postrst_latency", rise_cyc[0] - c0, 40);
        button_in = 2'b00; run(60);

        // Long hold on ch0: main build pulses once, LONG_PRESS_MS=0 build never
        clear_counts();
        button_in = 2'b01; run(200);
        button_in = 2'b00; run(60);
        chk("hold200_long0", long_cnt[0], 1);
        chk("nolong_never", nolong_cnt, 0);
        chk("nolong_valid_low", int'(nl_valid), 0);
        chk("pulse_consistency", pulse_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_deb_multi
`default_nettype wire
